motor_dir_sequencer: RTL
========================

# motor_dir_sequencer

Sequences one motor channel's H-bridge direction bits and PWM duty so direction reversals are always safe. It accepts drive commands (mode + duty), ramps duty down to zero, holds a coast dead-time and switches direction. It then ramps duty up to the new target, and an emergency stop overrides everything. It sits between the command source (PS2 decode / AXI registers) and the direction latch and PWM compare of the car's motor path; `mode_out` drives the `{dir_out1,dir_out2}` pair directly.

## Interface
- `DUTY_W`, 8: width of duty command/output.
- `RAMP_DIV`, 16: clock cycles per ±1 duty step; must be ≥1.
- `DEAD_CYCLES`, 1000: coast cycles between opposite drive directions; must be ≥1.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block accepts the command this cycle.
- `cmd_mode` in 2: 2'b10 forward, 2'b01 reverse, 2'b00 coast, 2'b11 brake.
- `cmd_duty` in DUTY_W: target duty; ignored (treated as 0) for coast/brake.
- `estop` in 1: level-sensitive emergency stop.
- `mode_out` out 2: registered direction bits to the H-bridge.
- `duty_out` out DUTY_W: registered duty to the PWM compare.
- `busy` out 1: high in DOWN, DEAD, STOP.

## Operation
- States: RUN, DOWN, DEAD, STOP. Registers: cur mode (`mode_out`), `duty_out`, tgt_mode, tgt_duty, prescaler (0..RAMP_DIV-1), dead counter (width clog2(DEAD_CYCLES+1)).
- `cmd_ready` = (state==RUN) & ~estop & ~rst. Accept = `cmd_valid & cmd_ready`; on accept latch tgt_mode/tgt_duty and clear prescaler.
- Accept in RUN, with the target resolved by the first matching rule:
  - tgt_mode == 11 (brake): next edge `mode_out`=11, `duty_out`=0, stay RUN.
  - tgt_mode == `mode_out`: stay RUN and ramp toward tgt_duty.
  - `duty_out`==0 and `mode_out` ∈ {00,11}: next edge `mode_out`=tgt_mode, stay RUN and ramp.
  - Otherwise go to DOWN.
- RUN: on prescaler wrap, `duty_out` moves 1 toward tgt_duty. No overshoot; holds when equal.
- DOWN: `mode_out` unchanged. On prescaler wrap `duty_out` decrements; there is no underflow, the minimum is 0. When `duty_out`==0 at a wrap, or on entry if already 0:
  - tgt_mode==00: `mode_out`=00 and go to RUN.
  - Else: `mode_out`=00, load the dead counter, go to DEAD.
- DEAD: `mode_out`=00, `duty_out`=0. Count DEAD_CYCLES cycles, then `mode_out`=tgt_mode, clear prescaler, go to RUN (ramp from 0).
- STOP: entered from any state on the edge where `estop`=1.
  - That edge sets `mode_out`=11 and `duty_out`=0, and tgt is set to 00/0.
  - Remains in STOP while `estop`=1.
  - When `estop` falls, enter DEAD with target coast; after DEAD_CYCLES go to RUN with `mode_out`=00.
- Priority per edge: `rst` > `estop` > state logic > command accept. A command presented with `estop` high is not accepted.

## Timing
- Reset values: `mode_out`=00, `duty_out`=0, state RUN, prescaler 0, tgt 00/0, `busy`=0. `cmd_ready`=0 while `rst`=1 and 1 on the first cycle after.
- `rst` mid-operation (any state) takes effect on that edge; the sequence in progress is abandoned.
- Outputs are registered. Brake/estop/mode-switch reaches `mode_out` 1 cycle after the accept/assert edge.
- First ramp step occurs RAMP_DIV cycles after accept or state entry, then every RAMP_DIV cycles.
- Full reversal from duty D to duty E takes D·RAMP_DIV (down) + DEAD_CYCLES (coast) + E·RAMP_DIV (up) cycles. `cmd_ready` returns high on RUN entry, before the up-ramp finishes.
- A new accept in RUN mid-ramp retargets immediately and clears the prescaler.

## Test plan
- Reset (RAMP_DIV=4, DEAD_CYCLES=10, DUTY_W=8): hold `rst` 3 cycles -> `mode_out`=00, `duty_out`=0, `cmd_ready`=0 during reset and 1 after, `busy`=0.
- From reset, send cmd 10/duty 3 -> `mode_out`=10 next edge; `duty_out`=1, 2, 3 at 4, 8, 12 cycles after accept; holds at 3; `busy` never high.
- At fwd duty 3, send cmd 01/duty 5 -> `cmd_ready`=0; `duty_out` 2, 1, 0 at +4, +8, +12; `mode_out`=00 for 10 cycles; then `mode_out`=01 with `cmd_ready`=1; `duty_out` reaches 5 at 20 cycles later.
- Assert `estop` during DEAD with `cmd_valid`=1 -> next edge `mode_out`=11, `duty_out`=0, command not accepted. Release -> 10 cycles `mode_out`=00, then RUN with 00/0 and `cmd_ready`=1.
- At fwd duty 6, send cmd brake -> next edge 11/0. Then send cmd 01/duty 2 -> `mode_out`=01 next edge with no dead time; ramps to 2 in 8 cycles.
- Assert `rst` mid-DOWN (`duty_out`=4) -> next edge 00/0, state RUN, prescaler cleared.

Source files
------------

// File: rtl/motor_dir_sequencer.sv
// Direction/duty sequencer for one H-bridge channel.
// Drive commands ramp the duty toward a target. A change to the opposite
// direction first ramps the duty down to zero, then coasts for a dead-time,
// then switches direction and ramps up to the new target. Emergency stop
// brakes immediately and, once released, coasts for a dead-time before the
// channel will take commands again.
//
// Command handshake: a command transfers on a rising edge where both
// cmd_valid and cmd_ready are high. cmd_ready is high only in RUN with
// estop and rst both low. The source holds cmd_mode/cmd_duty stable while
// cmd_valid is high. A command that is not accepted is simply not taken;
// nothing is queued.
module motor_dir_sequencer #(
  parameter int DUTY_W      = 8,
  parameter int RAMP_DIV    = 16,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [DUTY_W-1:0] cmd_duty,
  input  logic              estop,
  output logic [1:0]        mode_out,
  output logic [DUTY_W-1:0] duty_out,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int CW = $clog2(DEAD_CYCLES + 1);

  localparam logic [1:0] M_COAST = 2'b00;
  localparam logic [1:0] M_REV   = 2'b01;
  localparam logic [1:0] M_FWD   = 2'b10;
  localparam logic [1:0] M_BRAKE = 2'b11;

  localparam logic [PW-1:0] PRESC_LAST = PW'(RAMP_DIV - 1);
  localparam logic [CW-1:0] DEAD_LOAD  = CW'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_DOWN = 2'd1,
    S_DEAD = 2'd2,
    S_STOP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [1:0]        tgt_mode_q, tgt_mode_d;
  logic [DUTY_W-1:0] tgt_duty_q, tgt_duty_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     dead_q, dead_d;

  logic              wrap;
  logic              accept;
  logic [DUTY_W-1:0] cmd_tgt_duty;

  assign wrap         = (presc_q == PRESC_LAST);
  assign cmd_ready    = (state_q == S_RUN) & ~estop & ~rst;
  assign accept       = cmd_valid & cmd_ready;
  // Coast and brake carry no duty.
  assign cmd_tgt_duty = ((cmd_mode == M_FWD) || (cmd_mode == M_REV)) ? cmd_duty : '0;

  assign mode_out  = mode_q;
  assign duty_out  = duty_q;
  assign busy      = (state_q != S_RUN);
  assign dbg_state = state_q;

  // Next-state and next-output logic: estop first, then state behaviour,
  // with command acceptance folded into RUN.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    duty_d     = duty_q;
    tgt_mode_d = tgt_mode_q;
    tgt_duty_d = tgt_duty_q;
    presc_d    = wrap ? '0 : presc_q + 1'b1;
    dead_d     = dead_q;

    if (estop) begin
      state_d    = S_STOP;
      mode_d     = M_BRAKE;
      duty_d     = '0;
      tgt_mode_d = M_COAST;
      tgt_duty_d = '0;
      presc_d    = '0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (accept) begin
            tgt_mode_d = cmd_mode;
            tgt_duty_d = cmd_tgt_duty;
            presc_d    = '0;
            if (cmd_mode == M_BRAKE) begin
              mode_d = M_BRAKE;
              duty_d = '0;
            end else if (cmd_mode == mode_q) begin
              // Same direction: keep going, the ramp retargets.
            end else if ((duty_q == '0) && ((mode_q == M_COAST) || (mode_q == M_BRAKE))) begin
              // Not driving anything: switch straight over.
              mode_d = cmd_mode;
            end else if (duty_q == '0) begin
              // Driving at zero duty: nothing to ramp down, go straight to coast.
              mode_d = M_COAST;
              if (cmd_mode != M_COAST) begin
                state_d = S_DEAD;
                dead_d  = DEAD_LOAD;
              end
            end else begin
              state_d = S_DOWN;
            end
          end else if (wrap) begin
            if (duty_q < tgt_duty_q) begin
              duty_d = duty_q + 1'b1;
            end else if (duty_q > tgt_duty_q) begin
              duty_d = duty_q - 1'b1;
            end
          end
        end

        S_DOWN: begin
          if (wrap) begin
            if (duty_q <= DUTY_W'(1)) begin
              duty_d  = '0;
              mode_d  = M_COAST;
              presc_d = '0;
              if (tgt_mode_q == M_COAST) begin
                state_d = S_RUN;
              end else begin
                state_d = S_DEAD;
                dead_d  = DEAD_LOAD;
              end
            end else begin
              duty_d = duty_q - 1'b1;
            end
          end
        end

        S_DEAD: begin
          mode_d  = M_COAST;
          duty_d  = '0;
          presc_d = '0;
          if (dead_q <= CW'(1)) begin
            state_d = S_RUN;
            mode_d  = tgt_mode_q;
          end else begin
            dead_d = dead_q - 1'b1;
          end
        end

        S_STOP: begin
          // estop has just been released: coast out before taking commands.
          state_d = S_DEAD;
          mode_d  = M_COAST;
          duty_d  = '0;
          presc_d = '0;
          dead_d  = DEAD_LOAD;
        end

        default: begin
          state_d = S_RUN;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_RUN;
      mode_q     <= M_COAST;
      duty_q     <= '0;
      tgt_mode_q <= M_COAST;
      tgt_duty_q <= '0;
      presc_q    <= '0;
      dead_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      duty_q     <= duty_d;
      tgt_mode_q <= tgt_mode_d;
      tgt_duty_q <= tgt_duty_d;
      presc_q    <= presc_d;
      dead_q     <= dead_d;
    end
  end

endmodule
